// File: rtl/muldiv_pkg.sv
// Shared constants for the iterative multiply/divide unit: operation codes,
// FSM state encodings and the default datapath width.
package muldiv_pkg;

  localparam int MULDIV_WIDTH = 32;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;

endpackage

// File: rtl/muldiv_unit.sv
// Iterative MIPS multiply/divide unit: shift-add multiply and restoring divide,
// one bit per cycle, results landing in HI/LO with a start/busy/done handshake.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MULDIV_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] operand1,
  input  logic [WIDTH-1:0] operand2,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH);

  function automatic logic [WIDTH-1:0] negate_w(input logic [WIDTH-1:0] x);
    return ~x + 1'b1;
  endfunction

  function automatic logic [2*WIDTH-1:0] negate_2w(input logic [2*WIDTH-1:0] x);
    return ~x + 1'b1;
  endfunction

  logic [1:0]         state;
  logic [CNT_W-1:0]   count;
  logic               is_div, neg_res, neg_rem, dz_op;
  logic [WIDTH-1:0]   acc, mq, oprnd, orig1;

  logic               sgn_in, s1_in, s2_in;
  logic [WIDTH-1:0]   mag1_in, mag2_in;
  logic [WIDTH:0]     shifted, add_a, add_b;
  logic               add_cin;
  logic [WIDTH+1:0]   add_res;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   fix_hi, fix_lo;

  assign busy = (state == RUN) || (state == FIX);

  // Operand conditioning at capture: signed ops work on magnitudes.
  always_comb begin
    sgn_in  = (op == OP_MULT) || (op == OP_DIV);
    s1_in   = sgn_in & operand1[WIDTH-1];
    s2_in   = sgn_in & operand2[WIDTH-1];
    mag1_in = s1_in ? negate_w(operand1) : operand1;
    mag2_in = s2_in ? negate_w(operand2) : operand2;
  end

  // Shared adder: accumulate for multiply, trial subtract (a + ~b + 1) for divide.
  always_comb begin
    shifted = {acc, mq[WIDTH-1]};
    if (is_div) begin
      add_a   = shifted;
      add_b   = ~{1'b0, oprnd};
      add_cin = 1'b1;
    end else begin
      add_a   = {1'b0, acc};
      add_b   = mq[0] ? {1'b0, oprnd} : '0;
      add_cin = 1'b0;
    end
    add_res = {1'b0, add_a} + {1'b0, add_b} + (WIDTH+2)'(add_cin);
  end

  always_comb begin
    prod_fix = neg_res ? negate_2w({acc, mq}) : {acc, mq};
    if (dz_op) begin
      fix_hi = orig1;
      fix_lo = '1;
    end else if (is_div) begin
      fix_hi = neg_rem ? negate_w(acc) : acc;
      fix_lo = neg_res ? negate_w(mq) : mq;
    end else begin
      fix_hi = prod_fix[2*WIDTH-1:WIDTH];
      fix_lo = prod_fix[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      count       <= '0;
      hi          <= '0;
      lo          <= '0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= RUN;
            count <= '0;
          end else begin
            if (mthi) hi <= wdata;
            if (mtlo) lo <= wdata;
          end
        end
        RUN: begin
          count <= count + 1'b1;
          if (count == CNT_W'(WIDTH-1)) state <= FIX;
        end
        FIX: begin
          state       <= IDLE;
          hi          <= fix_hi;
          lo          <= fix_lo;
          done        <= 1'b1;
          div_by_zero <= dz_op;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Datapath registers carry no reset; they are always reloaded on start.
  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      is_div  <= op[1];
      neg_res <= s1_in ^ s2_in;
      neg_rem <= s1_in;
      dz_op   <= op[1] && (operand2 == '0);
      orig1   <= operand1;
      acc     <= '0;
      mq      <= op[1] ? mag1_in : mag2_in;
      oprnd   <= op[1] ? mag2_in : mag1_in;
    end else if (state == RUN) begin
      if (is_div) begin
        acc <= add_res[WIDTH+1] ? add_res[WIDTH-1:0] : shifted[WIDTH-1:0];
        mq  <= {mq[WIDTH-2:0], add_res[WIDTH+1]};
      end else begin
        acc <= add_res[WIDTH:1];
        mq  <= {add_res[0], mq[WIDTH-1:1]};
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: a vector table of operations with hand-computed
// HI/LO results, plus sequences for busy-time requests, mthi/mtlo and mid-run reset.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset, start, mthi, mtlo;
  logic [1:0]  op;
  logic [31:0] operand1, operand2, wdata;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo;

  int vectors = 0;
  int miscompares = 0;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .operand1(operand1), .operand2(operand2),
    .mthi(mthi), .mtlo(mtlo), .wdata(wdata),
    .busy(busy), .done(done), .div_by_zero(div_by_zero),
    .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    logic        exp_dz;
  } vec_t;

  vec_t tbl [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launches an operation and waits for done; lat counts edges after the start edge.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] r_hi, output logic [31:0] r_lo,
                        output logic r_dz, output int lat, output int busy_cyc);
    op = o; operand1 = a; operand2 = b; start = 1'b1;
    tick();
    start = 1'b0;
    operand1 = ~a; operand2 = ~b; op = ~o;
    lat = 0; busy_cyc = 0;
    while (!done && lat < 100) begin
      if (busy) busy_cyc++;
      tick();
      lat++;
    end
    r_hi = hi; r_lo = lo; r_dz = div_by_zero;
    if (lat >= 100) begin
      miscompares++;
      vectors++;
      $display("FAIL done_timeout: got no done within 100 cycles, expected done at 33");
    end
  endtask

  logic [31:0] r_hi, r_lo;
  logic        r_dz;
  int          lat, bcyc;
  bit          saw_done;

  initial begin
    tbl[0]  = '{OP_MULTU_C(), 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
    tbl[1]  = '{2'b00, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
    tbl[2]  = '{2'b11, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0};
    tbl[3]  = '{2'b10, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
    tbl[4]  = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
    tbl[5]  = '{2'b11, 32'h00001234, 32'h0,        32'h00001234, 32'hFFFFFFFF, 1'b1};
    tbl[6]  = '{2'b10, 32'h00001234, 32'h0,        32'h00001234, 32'hFFFFFFFF, 1'b1};
    tbl[7]  = '{2'b10, 32'hFFFFFFF9, 32'h0,        32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1};
    tbl[8]  = '{2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
    tbl[9]  = '{2'b01, 32'h12345678, 32'h0,        32'h00000000, 32'h00000000, 1'b0};
    tbl[10] = '{2'b10, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
    tbl[11] = '{2'b00, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 1'b0};

    reset = 1'b1; start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    op = 2'b00; operand1 = '0; operand2 = '0; wdata = '0;
    tick(); tick();
    reset = 1'b0;
    check("reset_hi", hi, 32'h0);
    check("reset_lo", lo, 32'h0);
    check("reset_ctl", {29'b0, busy, done, div_by_zero}, 32'h0);

    for (int i = 0; i < 12; i++) begin
      run_op(tbl[i].op, tbl[i].a, tbl[i].b, r_hi, r_lo, r_dz, lat, bcyc);
      check($sformatf("v%0d_hi", i), r_hi, tbl[i].exp_hi);
      check($sformatf("v%0d_lo", i), r_lo, tbl[i].exp_lo);
      check($sformatf("v%0d_dz", i), {31'b0, r_dz}, {31'b0, tbl[i].exp_dz});
      check($sformatf("v%0d_latency", i), lat, 32'd33);
      check($sformatf("v%0d_busy_cycles", i), bcyc, 32'd33);
      tick();
      check($sformatf("v%0d_done_pulse", i), {30'b0, done, div_by_zero}, 32'h0);
    end

    // mthi and mtlo together in IDLE
    wdata = 32'h55; mthi = 1'b1; mtlo = 1'b1;
    tick();
    mthi = 1'b0; mtlo = 1'b0;
    check("mt_both_hi", hi, 32'h55);
    check("mt_both_lo", lo, 32'h55);
    check("mt_no_done", {31'b0, done}, 32'h0);

    // start wins over a same-cycle mthi; mid-run start/mthi ignored
    op = 2'b01; operand1 = 32'd3; operand2 = 32'd5; start = 1'b1;
    mthi = 1'b1; wdata = 32'h77;
    tick();
    start = 1'b0; mthi = 1'b0;
    check("start_prio_hi", hi, 32'h55);
    repeat (5) tick();
    op = 2'b11; operand1 = 32'd9; operand2 = 32'd0; start = 1'b1;
    mthi = 1'b1; wdata = 32'hAAAA;
    tick();
    start = 1'b0; mthi = 1'b0;
    check("busy_mthi_hi", hi, 32'h55);
    check("busy_hold_lo", lo, 32'h55);
    check("busy_still", {31'b0, busy}, 32'h1);
    lat = 0;
    while (!done && lat < 100) begin
      if (lat == 20) check("run_hold_hi", hi, 32'h55);
      tick();
      lat++;
    end
    check("busy_seq_lat", lat, 32'd27);
    check("busy_seq_hi", hi, 32'h0);
    check("busy_seq_lo", lo, 32'd15);
    check("busy_seq_dz", {31'b0, div_by_zero}, 32'h0);
    repeat (3) tick();
    check("no_queued_start", {31'b0, busy}, 32'h0);

    // reset during RUN cycle 10 abandons the operation
    op = 2'b11; operand1 = 32'd100; operand2 = 32'd7; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (10) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_mid_busy", {31'b0, busy}, 32'h0);
    check("rst_mid_hi", hi, 32'h0);
    check("rst_mid_lo", lo, 32'h0);
    saw_done = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (done) saw_done = 1'b1;
      tick();
    end
    check("rst_mid_no_done", {31'b0, saw_done}, 32'h0);
    run_op(2'b00, 32'hFFFFFFFD, 32'd7, r_hi, r_lo, r_dz, lat, bcyc);
    check("post_rst_hi", r_hi, 32'hFFFFFFFF);
    check("post_rst_lo", r_lo, 32'hFFFFFFEB);
    check("post_rst_lat", lat, 32'd33);

    // start asserted during the done cycle is accepted at the next edge
    op = 2'b11; operand1 = 32'd100; operand2 = 32'd7; start = 1'b1;
    tick();
    check("done_cycle_start_busy", {31'b0, busy}, 32'h1);
    start = 1'b0;
    lat = 0;
    while (!done && lat < 100) begin tick(); lat++; end
    check("done_cycle_start_hi", hi, 32'd2);
    check("done_cycle_start_lo", lo, 32'd14);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  function automatic logic [1:0] OP_MULTU_C();
    return 2'b01;
  endfunction

endmodule
